// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD card SPI command master.
package sd_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAW,
    ST_CMD,
    ST_POLL,
    ST_DONE
  } state_e;

  localparam int unsigned SD_FRAME_BYTES = 6;
  localparam logic [7:0]  SD_CMD_START   = 8'h40;
  localparam logic [7:0]  SD_POLL_BYTE   = 8'hFF;
  localparam logic [7:0]  SD_R1_IDLE     = 8'h01;

  // First byte of a command frame: start/transmission bits plus the index.
  function automatic logic [7:0] sd_cmd_byte0(input logic [5:0] index);
    return SD_CMD_START | {2'b00, index};
  endfunction

endpackage

// File: rtl/sd_spi_cmd_if.sv
// Core-side request/response bundle of the SD SPI command master.
interface sd_spi_cmd_if;
  logic        cs_assert;
  logic        xfer_start;
  logic [7:0]  xfer_din;
  logic [7:0]  xfer_dout;
  logic        xfer_done;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [7:0]  cmd_crc;
  logic [7:0]  cmd_r1;
  logic        cmd_timeout;
  logic        cmd_done;
  logic        busy;

  modport master (
    output cs_assert, xfer_start, xfer_din, cmd_start, cmd_index, cmd_arg, cmd_crc,
    input  xfer_dout, xfer_done, cmd_r1, cmd_timeout, cmd_done, busy
  );

  modport slave (
    input  cs_assert, xfer_start, xfer_din, cmd_start, cmd_index, cmd_arg, cmd_crc,
    output xfer_dout, xfer_done, cmd_r1, cmd_timeout, cmd_done, busy
  );
endinterface

// File: rtl/sd_spi_byte.sv
// SPI mode-0 byte engine: SCK divider plus a shared TX/RX shift register.
module sd_spi_byte #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       sdo,
  output logic       sck,
  output logic       sdi,
  output logic [7:0] dout,
  output logic       done_c
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic       active_q, active_d;
  logic       sck_q, sck_d;
  logic       sdi_q, sdi_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sr_q, sr_d;
  logic       edge_c;

  assign edge_c = active_q && (div_q == DIV_LAST);
  assign done_c = edge_c && sck_q && (bit_q == 3'd7);

  // A start coinciding with the last falling edge reloads without an SCK gap.
  always_comb begin
    active_d = active_q;
    sck_d    = sck_q;
    sdi_d    = sdi_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    if (active_q) begin
      if (edge_c) begin
        div_d = 8'd0;
        sck_d = ~sck_q;
        if (!sck_q) begin
          sr_d = {sr_q[6:0], sdo};
        end else if (bit_q == 3'd7) begin
          active_d = 1'b0;
          sdi_d    = 1'b1;
          bit_d    = 3'd0;
        end else begin
          bit_d = bit_q + 3'd1;
          sdi_d = sr_q[7];
        end
      end else begin
        div_d = div_q + 8'd1;
      end
    end
    if (start) begin
      active_d = 1'b1;
      sck_d    = 1'b0;
      div_d    = 8'd0;
      bit_d    = 3'd0;
      sr_d     = din;
      sdi_d    = din[7];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      sdi_q    <= 1'b1;
      div_q    <= 8'd0;
      bit_q    <= 3'd0;
      sr_q     <= 8'hFF;
    end else begin
      active_q <= active_d;
      sck_q    <= sck_d;
      sdi_q    <= sdi_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sr_q     <= sr_d;
    end
  end

  assign sck  = sck_q;
  assign sdi  = sdi_q;
  assign dout = sr_q;

endmodule

// File: rtl/sd_spi_cmd.sv
// SD card SPI master: raw byte transfers plus framed commands with R1 polling.
module sd_spi_cmd
  import sd_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned RESP_TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  sd_spi_cmd_if.slave  bus,
  output logic         sd_cs,
  output logic         sd_sck,
  output logic         sd_sdi,
  input  logic         sd_sdo
);

  localparam logic [2:0] LAST_IDX  = 3'(SD_FRAME_BYTES - 1);
  localparam logic [7:0] POLL_LAST = 8'(RESP_TIMEOUT);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  poll_q, poll_d;
  logic [39:0] frame_q, frame_d;
  logic [7:0]  xfer_dout_q, xfer_dout_d;
  logic        xfer_done_q, xfer_done_d;
  logic [7:0]  cmd_r1_q, cmd_r1_d;
  logic        cmd_timeout_q, cmd_timeout_d;
  logic        cmd_done_q, cmd_done_d;
  logic        busy_q, busy_d;
  logic        sd_cs_q, sd_cs_d;
  logic        start_c;
  logic [7:0]  din_c;
  logic [7:0]  byte_dout;
  logic        byte_done_c;

  sd_spi_byte #(.CLK_DIV(CLK_DIV)) u_byte (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start_c),
    .din    (din_c),
    .sdo    (sd_sdo),
    .sck    (sd_sck),
    .sdi    (sd_sdi),
    .dout   (byte_dout),
    .done_c (byte_done_c)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    poll_d        = poll_q;
    frame_d       = frame_q;
    xfer_dout_d   = xfer_dout_q;
    xfer_done_d   = 1'b0;
    cmd_r1_d      = cmd_r1_q;
    cmd_timeout_d = cmd_timeout_q;
    cmd_done_d    = 1'b0;
    sd_cs_d       = ~bus.cs_assert;
    start_c       = 1'b0;
    din_c         = SD_POLL_BYTE;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_start) begin
          state_d = ST_CMD;
          idx_d   = 3'd0;
          frame_d = {bus.cmd_arg, bus.cmd_crc | 8'h01};
          start_c = 1'b1;
          din_c   = sd_cmd_byte0(bus.cmd_index);
        end else if (bus.xfer_start) begin
          state_d = ST_RAW;
          start_c = 1'b1;
          din_c   = bus.xfer_din;
        end
      end
      ST_RAW: begin
        if (byte_done_c) begin
          state_d     = ST_IDLE;
          xfer_dout_d = byte_dout;
          xfer_done_d = 1'b1;
        end
      end
      // Frame bytes after the first are shifted out of frame_q, MSB byte first.
      ST_CMD: begin
        if (byte_done_c) begin
          start_c = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_POLL;
            poll_d  = 8'd0;
          end else begin
            din_c   = frame_q[39:32];
            frame_d = {frame_q[31:0], SD_POLL_BYTE};
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      ST_POLL: begin
        if (byte_done_c) begin
          if (!byte_dout[7]) begin
            state_d       = ST_DONE;
            cmd_r1_d      = byte_dout;
            cmd_timeout_d = 1'b0;
          end else if (poll_q + 8'd1 == POLL_LAST) begin
            state_d       = ST_DONE;
            poll_d        = poll_q + 8'd1;
            cmd_r1_d      = SD_POLL_BYTE;
            cmd_timeout_d = 1'b1;
          end else begin
            poll_d  = poll_q + 8'd1;
            start_c = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        cmd_done_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= 3'd0;
      poll_q        <= 8'd0;
      frame_q       <= 40'd0;
      xfer_dout_q   <= 8'hFF;
      xfer_done_q   <= 1'b0;
      cmd_r1_q      <= 8'hFF;
      cmd_timeout_q <= 1'b0;
      cmd_done_q    <= 1'b0;
      busy_q        <= 1'b0;
      sd_cs_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      poll_q        <= poll_d;
      frame_q       <= frame_d;
      xfer_dout_q   <= xfer_dout_d;
      xfer_done_q   <= xfer_done_d;
      cmd_r1_q      <= cmd_r1_d;
      cmd_timeout_q <= cmd_timeout_d;
      cmd_done_q    <= cmd_done_d;
      busy_q        <= busy_d;
      sd_cs_q       <= sd_cs_d;
    end
  end

  assign sd_cs           = sd_cs_q;
  assign bus.xfer_dout   = xfer_dout_q;
  assign bus.xfer_done   = xfer_done_q;
  assign bus.cmd_r1      = cmd_r1_q;
  assign bus.cmd_timeout = cmd_timeout_q;
  assign bus.cmd_done    = cmd_done_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_sd_spi_cmd.sv
// Self-checking bench for sd_spi_cmd: behavioural SPI slave plus a transaction-level model.
module tb_sd_spi_cmd;
  import sd_spi_pkg::*;

  localparam int unsigned D      = 4;
  localparam int unsigned RT     = 8;
  localparam int unsigned BUDGET = (SD_FRAME_BYTES + RT) * 16 * D + 50;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sd_cs, sd_sck, sd_sdi;
  logic sd_sdo = 1'b1;

  sd_spi_cmd_if bus ();

  sd_spi_cmd #(.CLK_DIV(D), .RESP_TIMEOUT(RT)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .sd_cs  (sd_cs),
    .sd_sck (sd_sck),
    .sd_sdi (sd_sdi),
    .sd_sdo (sd_sdo)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Done-pulse counters sampled away from the active edge.
  int xd_cnt = 0;
  int cd_cnt = 0;
  always @(negedge clk) begin
    if (bus.xfer_done === 1'b1) xd_cnt++;
    if (bus.cmd_done === 1'b1) cd_cnt++;
  end

  // SPI slave: replays resp_mem MSB first, logs every MOSI byte.
  logic [7:0] resp_mem [0:63];
  int         resp_len = 0;
  logic [7:0] mosi_mem [0:63];
  int         mosi_cnt = 0;
  logic       slv_req = 1'b0;
  logic [7:0] tx_cur = 8'hFF;
  logic [7:0] rx = 8'h00;
  logic [2:0] bitn = 3'd0;
  int         rd_idx = 0;

  always @(posedge sd_sck or negedge sd_sck or posedge slv_req) begin
    if (slv_req) begin
      bitn     = 3'd0;
      rx       = 8'h00;
      mosi_cnt = 0;
      tx_cur   = (resp_len > 0) ? resp_mem[0] : 8'hFF;
      rd_idx   = 1;
      sd_sdo   = tx_cur[7];
    end else if (sd_sck) begin
      rx = {rx[6:0], sd_sdi};
      if (bitn == 3'd7) begin
        if (mosi_cnt < 64) mosi_mem[mosi_cnt] = rx;
        mosi_cnt++;
        bitn = 3'd0;
      end else begin
        bitn = bitn + 3'd1;
      end
    end else begin
      if (bitn == 3'd0) begin
        tx_cur = (rd_idx < resp_len) ? resp_mem[rd_idx] : 8'hFF;
        rd_idx++;
      end
      sd_sdo = tx_cur[3'd7 - bitn];
    end
  end

  task automatic slave_load();
    slv_req = 1'b1;
    #1;
    slv_req = 1'b0;
  endtask

  task automatic do_raw(input logic [7:0] din, input logic [7:0] resp, input string tag);
    int k;
    int unsigned t0;
    resp_mem[0] = resp;
    resp_len = 1;
    slave_load();
    @(negedge clk);
    bus.xfer_din = din;
    bus.xfer_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    bus.xfer_start = 1'b0;
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    k = 0;
    while (bus.xfer_done !== 1'b1 && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_nohang"}, 64'(k < BUDGET), 64'd1);
    chk({tag, "_lat"}, 64'(cyc - t0), 64'(16 * D + 1));
    chk({tag, "_dout"}, 64'(bus.xfer_dout), 64'(resp));
    chk({tag, "_sck_low"}, 64'(sd_sck), 64'd0);
    chk({tag, "_mosi_n"}, 64'(mosi_cnt), 64'd1);
    chk({tag, "_mosi"}, 64'(mosi_mem[0]), 64'(din));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(bus.xfer_done), 64'd0);
    chk({tag, "_idle"}, 64'({bus.busy, sd_sdi}), 64'b01);
  endtask

  // Model: frame bytes, then poll until a byte with bit 7 clear or RT polls.
  task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc,
                        input string tag, input bit collide);
    logic [7:0] exp_b [0:5];
    logic [7:0] exp_r1, b;
    logic       exp_to;
    int         n, k, xd0, cd0;
    int unsigned t0;
    exp_b[0] = 8'h40 + 8'(idx);
    exp_b[1] = arg[31:24];
    exp_b[2] = arg[23:16];
    exp_b[3] = arg[15:8];
    exp_b[4] = arg[7:0];
    exp_b[5] = {crc[7:1], 1'b1};
    exp_r1 = 8'hFF;
    exp_to = 1'b1;
    n = 0;
    for (int p = 0; p < int'(RT); p++) begin
      b = (6 + p < resp_len) ? resp_mem[6 + p] : 8'hFF;
      n = p + 1;
      if (b < 8'h80) begin
        exp_r1 = b;
        exp_to = 1'b0;
        break;
      end
    end
    slave_load();
    xd0 = xd_cnt;
    cd0 = cd_cnt;
    @(negedge clk);
    bus.cmd_index = idx;
    bus.cmd_arg = arg;
    bus.cmd_crc = crc;
    bus.cmd_start = 1'b1;
    if (collide) begin
      bus.xfer_start = 1'b1;
      bus.xfer_din = 8'($urandom);
    end
    t0 = cyc;
    @(negedge clk);
    bus.cmd_start = 1'b0;
    bus.xfer_start = 1'b0;
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    chk({tag, "_cs"}, 64'(sd_cs), 64'd0);
    if (collide) begin
      repeat (20) @(negedge clk);
      bus.cmd_index = ~idx;
      bus.cmd_arg = ~arg;
      bus.cmd_start = 1'b1;
      bus.xfer_start = 1'b1;
      @(negedge clk);
      bus.cmd_start = 1'b0;
      bus.xfer_start = 1'b0;
    end
    k = 0;
    while (bus.cmd_done !== 1'b1 && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_nohang"}, 64'(k < BUDGET), 64'd1);
    chk({tag, "_lat"}, 64'(cyc - t0), 64'((6 + n) * 16 * D + 2));
    chk({tag, "_r1"}, 64'(bus.cmd_r1), 64'(exp_r1));
    chk({tag, "_timeout"}, 64'(bus.cmd_timeout), 64'(exp_to));
    chk({tag, "_mosi_n"}, 64'(mosi_cnt), 64'(6 + n));
    for (int i = 0; i < 6 + n && i < 64; i++)
      chk($sformatf("%s_mosi%0d", tag, i), 64'(mosi_mem[i]), 64'((i < 6) ? exp_b[i] : 8'hFF));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(bus.cmd_done), 64'd0);
    chk({tag, "_idle"}, 64'({bus.busy, sd_sdi, sd_sck}), 64'b010);
    if (collide) begin
      repeat (10) @(negedge clk);
      chk({tag, "_no_xdone"}, 64'(xd_cnt - xd0), 64'd0);
      chk({tag, "_one_cdone"}, 64'(cd_cnt - cd0), 64'd1);
      chk({tag, "_not_queued"}, 64'(bus.busy), 64'd0);
    end
  endtask

  // Response stream for a command: k non-R1 bytes after the frame, then R1.
  task automatic set_resp(input int k, input logic [7:0] r1);
    for (int i = 0; i < 6; i++) resp_mem[i] = 8'($urandom);
    for (int p = 0; p < k; p++) resp_mem[6 + p] = 8'($urandom) | 8'h80;
    resp_mem[6 + k] = r1;
    resp_len = 7 + k;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cs"}, 64'(sd_cs), 64'd1);
    chk({tag, "_sck"}, 64'(sd_sck), 64'd0);
    chk({tag, "_sdi"}, 64'(sd_sdi), 64'd1);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_xdone"}, 64'(bus.xfer_done), 64'd0);
    chk({tag, "_cdone"}, 64'(bus.cmd_done), 64'd0);
    chk({tag, "_timeout"}, 64'(bus.cmd_timeout), 64'd0);
    chk({tag, "_xdout"}, 64'(bus.xfer_dout), 64'hFF);
    chk({tag, "_r1"}, 64'(bus.cmd_r1), 64'hFF);
  endtask

  initial begin
    int k;
    bus.cs_assert = 1'b0;
    bus.xfer_start = 1'b0;
    bus.xfer_din = 8'h00;
    bus.cmd_start = 1'b0;
    bus.cmd_index = 6'd0;
    bus.cmd_arg = 32'd0;
    bus.cmd_crc = 8'd0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    reset_n = 1'b1;
    bus.cs_assert = 1'b1;
    repeat (2) @(negedge clk);

    do_raw(8'hA5, 8'h3C, "raw_a5");

    set_resp(3, SD_R1_IDLE);
    do_cmd(6'd0, 32'd0, 8'h95, "cmd0", 1'b0);

    set_resp(1, SD_R1_IDLE);
    do_cmd(6'd8, 32'h0000_01AA, 8'h87, "cmd8", 1'b0);
    do_raw(8'hFF, 8'h00, "cmd8_r7a");
    do_raw(8'hFF, 8'h00, "cmd8_r7b");
    do_raw(8'hFF, 8'h01, "cmd8_r7c");
    do_raw(8'hFF, 8'hAA, "cmd8_r7d");

    resp_len = 0;
    do_cmd(6'd55, 32'h1234_5678, 8'h00, "tmo", 1'b0);

    set_resp(2, 8'h05);
    do_cmd(6'd17, 32'hDEAD_BEEF, 8'h3A, "collide", 1'b1);

    // Reset in the middle of command byte 3.
    set_resp(3, SD_R1_IDLE);
    slave_load();
    @(negedge clk);
    bus.cmd_index = 6'd0;
    bus.cmd_arg = 32'd0;
    bus.cmd_crc = 8'h95;
    bus.cmd_start = 1'b1;
    @(negedge clk);
    bus.cmd_start = 1'b0;
    k = 0;
    while (mosi_cnt < 3 && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    chk("midrst_reach", 64'(k < BUDGET), 64'd1);
    repeat (3 * D) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    set_resp(3, SD_R1_IDLE);
    do_cmd(6'd0, 32'd0, 8'h95, "post_rst_cmd0", 1'b0);

    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_raw(8'($urandom), 8'($urandom), $sformatf("rnd%0d_raw", it));
      end else begin
        set_resp(int'($urandom_range(0, RT + 1)), 8'($urandom) & 8'h7F);
        do_cmd(6'($urandom), $urandom, 8'($urandom), $sformatf("rnd%0d_cmd", it), 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sd_spi_cmd.md
# sd_spi_cmd

Core-side SPI master for the SD card SPI slave. It drives `sd_cs`, `sd_sck` and `sd_sdi` and samples `sd_sdo`. It offers a raw byte-transfer port and a command port that frames a 6-byte SD command and polls for the R1 response. The core's disk/ROM loader sits upstream; the SD card SPI slave (and through it the io controller) sits downstream.

## Interface
Parameters:
- `CLK_DIV`, 4: clk cycles per SCK half-period; legal range 1..255.
- `RESP_TIMEOUT`, 8: maximum number of 0xFF poll bytes sent while waiting for R1; legal range 1..255.

Ports (one clock `clk`, reset `reset_n`, asynchronous, active-low):
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset.
- `cs_assert` in 1: level input; 1 drives `sd_cs` low (selected).
- `xfer_start` in 1: single-cycle pulse that starts a raw byte transfer; accepted only when `busy`=0.
- `xfer_din` in 8: byte to send, captured on the `xfer_start` cycle.
- `xfer_dout` out 8: byte received by the last raw transfer.
- `xfer_done` out 1: single-cycle pulse when a raw transfer ends.
- `cmd_start` in 1: single-cycle pulse that starts a command; accepted only when `busy`=0. If it arrives together with `xfer_start`, `cmd_start` wins.
- `cmd_index` in 6, `cmd_arg` in 32, `cmd_crc` in 8: captured on the `cmd_start` cycle. `cmd_crc` is sent as-is and its bit 0 is forced to 1.
- `cmd_r1` out 8: R1 response byte, or 0xFF on timeout.
- `cmd_timeout` out 1: valid with `cmd_done`; set when no R1 arrived.
- `cmd_done` out 1: single-cycle pulse when a command ends.
- `busy` out 1: high from the cycle after an accepted start until the done pulse.
- `sd_cs` out 1, `sd_sck` out 1, `sd_sdi` out 1: SPI outputs.
- `sd_sdo` in 1: SPI input.

## Operation
- SPI mode 0, MSB first. SCK idles low. `sd_sdi` changes on SCK falling edges or before the first rising edge. `sd_sdo` is sampled on SCK rising edges.
- `sd_cs` = `~cs_assert`, registered (one cycle of delay). It is independent of the state machine, so dropping `cs_assert` mid-transfer does not abort the transfer.
- Byte engine:
  - Shift register, 3-bit bit counter, divider counter.
  - One byte = 8 bits × 2 half-periods × `CLK_DIV` clk cycles.
  - Received byte = the 8 sampled bits, MSB first.
- States:
  - IDLE
    - `cmd_start` → CMD: load byte list {0x40|`cmd_index`, `cmd_arg`[31:24], [23:16], [15:8], [7:0], `cmd_crc`|1}, byte counter = 0.
    - `xfer_start` → RAW.
  - RAW: shift one byte; at its end → IDLE, `xfer_dout` updated, pulse `xfer_done`.
  - CMD: shift bytes 0..5; after byte 5 → POLL, poll counter = 0.
  - POLL: send 0xFF.
    - Received byte with bit 7 = 0 → DONE with `cmd_r1` = that byte, `cmd_timeout` = 0.
    - Otherwise increment the poll counter. When it reaches `RESP_TIMEOUT` → DONE with `cmd_r1` = 0xFF, `cmd_timeout` = 1.
  - DONE: pulse `cmd_done` for one cycle → IDLE.
- Start pulses while `busy`=1 are ignored and not queued.
- The block never reads the data token or data block itself. The caller uses RAW transfers for those.

## Timing
- Reset values: `sd_cs`=1, `sd_sck`=0, `sd_sdi`=1, `busy`=0, `xfer_done`=0, `cmd_done`=0, `cmd_timeout`=0, `xfer_dout`=0xFF, `cmd_r1`=0xFF. State = IDLE, all counters 0.
- Reset asserted mid-transfer: all of the above apply immediately, and SCK returns low asynchronously.
- `busy` rises on the cycle after the start pulse. The first SCK rising edge occurs `CLK_DIV` cycles after that.
- RAW latency: `xfer_done` fires 16×`CLK_DIV`+1 cycles after `xfer_start`. `sd_sck` is low again when `xfer_done` pulses.
- Command latency: (6 + n)×16×`CLK_DIV` + 2 cycles, where n = number of poll bytes including the R1 byte. n ≤ `RESP_TIMEOUT`.
- Consecutive bytes inside CMD/POLL have no SCK gap. Between separate RAW transfers, SCK stays low for at least 1 cycle.
- `sd_sdi` idles at 1 whenever `busy`=0.

## Structure
- Shared package `sd_spi_pkg`:
  - state enum (IDLE, RAW, CMD, POLL, DONE)
  - `SD_CMD_START` = 0x40
  - `SD_POLL_BYTE` = 0xFF
  - R1 idle bit mask = 0x01
- One natural sub-module: `sd_spi_byte`, the divider plus shift engine with `start`/`din`/`dout`/`done`. `sd_spi_cmd` sequences it.

## Test plan
- Reset with `CLK_DIV`=4, then RAW `xfer_din`=0xA5 against a slave echoing 0x3C → SDI carries 10100101 MSB first; `xfer_dout`=0x3C; `xfer_done` 65 cycles after start.
- CMD0 (`cmd_index`=0, `cmd_arg`=0, `cmd_crc`=0x95) against the SD card model → SDI bytes 40 00 00 00 00 95. The slave answers after 3 FF bytes, so `cmd_r1`=0x01, `cmd_timeout`=0, n=4.
- CMD8 `cmd_arg`=0x000001AA, then 4 RAW transfers → `cmd_r1`=0x01; raw bytes 00 00 01 AA.
- Slave holding SDO high, `RESP_TIMEOUT`=8 → exactly 8 poll bytes; `cmd_r1`=0xFF, `cmd_timeout`=1.
- `xfer_start` and `cmd_start` in the same cycle, plus a second `cmd_start` while `busy` → command runs; the second start is ignored and there is no `xfer_done`.
- `reset_n` low during CMD byte 3 → outputs return to their reset values at once. A new CMD0 after release completes normally.
